// File: rtl/datapath_input_ctrl_if.sv
// CPU-read request and input-datapath control bundle for datapath_input_ctrl.
// The master side is the CPU bus FSM plus device; the slave side is the controller.
interface datapath_input_ctrl_if;
  logic i_req;
  logic i_size32;
  logic i_a1;
  logic i_port16;
  logic i_dev_ack;
  logic o_dev_req;
  logic o_dev_a1;
  logic o_ds_o_n;
  logic o_bdieh;
  logic o_bdiel;
  logic o_bbridgein;
  logic o_ack;
  logic o_berr;
  logic o_busy;

  modport master (
    output i_req, i_size32, i_a1, i_port16, i_dev_ack,
    input  o_dev_req, o_dev_a1, o_ds_o_n, o_bdieh, o_bdiel, o_bbridgein,
           o_ack, o_berr, o_busy
  );

  modport slave (
    input  i_req, i_size32, i_a1, i_port16, i_dev_ack,
    output o_dev_req, o_dev_a1, o_ds_o_n, o_bdieh, o_bdiel, o_bbridgein,
           o_ack, o_berr, o_busy
  );
endinterface

// File: rtl/datapath_input_ctrl.sv
// Input datapath sequencer: one CPU read becomes one or two device fetches.
// Optional DEV_ACK timeout / bus error enabled by DATAPATH_INPUT_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for REQ, attributes captured on REQ
//   DEV   | device strobe out, waiting for DEV_ACK
//   LATCH | DS_O_ low, upper lanes captured into the upper-data latch
//   GAP   | strobe released between the two halves of a 16-bit longword
//   DRIVE | lane enables held HOLD_CYCLES, ACK in the last cycle
module datapath_input_ctrl #(
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  datapath_input_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEV   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRIVE = 3'd4;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("datapath_input_ctrl: HOLD_CYCLES or TIMEOUT_CYCLES out of range");
  end

  logic [2:0] r_state;
  logic       r_size32;
  logic       r_a1;
  logic       r_port16;
  logic       r_half;
  logic [3:0] r_hold;

  logic       r_dev_req;
  logic       r_dev_a1;
  logic       r_ds_o_n;
  logic       r_bdieh;
  logic       r_bdiel;
  logic       r_bbridgein;
  logic       r_ack;
  logic       r_berr;
  logic       r_busy;

  logic [2:0] w_nxt_state;
  logic       w_nxt_size32;
  logic       w_nxt_a1;
  logic       w_nxt_port16;
  logic       w_nxt_half;
  logic [3:0] w_nxt_hold;
  logic       w_nxt_dev_a1;
  logic       w_expire;
  logic       w_nxt_drive;

`ifdef DATAPATH_INPUT_TIMEOUT_EN
  logic [7:0] r_tmo;

  assign w_expire = (r_state == S_DEV) && !bus.i_dev_ack &&
                    (r_tmo == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_tmo <= '0;
    else if (r_state == S_DEV && w_nxt_state == S_DEV)
      r_tmo <= r_tmo + 8'd1;
    else
      r_tmo <= '0;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_size32 = r_size32;
    w_nxt_a1     = r_a1;
    w_nxt_port16 = r_port16;
    w_nxt_half   = r_half;
    w_nxt_hold   = r_hold;
    w_nxt_dev_a1 = r_dev_a1;
    case (r_state)
      S_IDLE: begin
        w_nxt_dev_a1 = 1'b0;
        if (bus.i_req) begin
          w_nxt_state  = S_DEV;
          w_nxt_size32 = bus.i_size32;
          // A1 has no meaning for a longword; folding it here keeps later decode simple
          w_nxt_a1     = bus.i_a1 & ~bus.i_size32;
          w_nxt_port16 = bus.i_port16;
          w_nxt_half   = 1'b0;
          w_nxt_dev_a1 = (bus.i_port16 & bus.i_size32) | (bus.i_a1 & ~bus.i_size32);
        end
      end
      S_DEV: begin
        if (bus.i_dev_ack) begin
          if (r_port16 & (r_a1 | (r_size32 & ~r_half))) begin
            w_nxt_state = S_LATCH;
          end else begin
            w_nxt_state = S_DRIVE;
            w_nxt_hold  = HOLD_LOAD;
          end
        end else if (w_expire) begin
          w_nxt_state  = S_IDLE;
          w_nxt_dev_a1 = 1'b0;
        end
      end
      S_LATCH: begin
        if (r_size32) begin
          w_nxt_state  = S_GAP;
          w_nxt_half   = 1'b1;
          w_nxt_dev_a1 = 1'b0;
        end else begin
          w_nxt_state = S_DRIVE;
          w_nxt_hold  = HOLD_LOAD;
        end
      end
      S_GAP: begin
        w_nxt_state = S_DEV;
      end
      S_DRIVE: begin
        if (r_hold == 4'd0) begin
          w_nxt_state  = S_IDLE;
          w_nxt_dev_a1 = 1'b0;
        end else begin
          w_nxt_hold = r_hold - 4'd1;
        end
      end
      default: begin
        w_nxt_state  = S_IDLE;
        w_nxt_dev_a1 = 1'b0;
      end
    endcase
  end

  assign w_nxt_drive = (w_nxt_state == S_DRIVE);

  // Outputs are decoded from the next state so each one is a plain flop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_size32    <= 1'b0;
      r_a1        <= 1'b0;
      r_port16    <= 1'b0;
      r_half      <= 1'b0;
      r_hold      <= 4'd0;
      r_dev_req   <= 1'b0;
      r_dev_a1    <= 1'b0;
      r_ds_o_n    <= 1'b1;
      r_bdieh     <= 1'b0;
      r_bdiel     <= 1'b0;
      r_bbridgein <= 1'b0;
      r_ack       <= 1'b0;
      r_berr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_size32    <= w_nxt_size32;
      r_a1        <= w_nxt_a1;
      r_port16    <= w_nxt_port16;
      r_half      <= w_nxt_half;
      r_hold      <= w_nxt_hold;
      r_dev_req   <= (w_nxt_state == S_DEV) || (w_nxt_state == S_LATCH) || w_nxt_drive;
      r_dev_a1    <= w_nxt_dev_a1;
      r_ds_o_n    <= (w_nxt_state != S_LATCH);
      r_bdieh     <= w_nxt_drive & (~r_port16 | ~r_a1);
      r_bdiel     <= w_nxt_drive & ~r_port16;
      r_bbridgein <= w_nxt_drive & r_port16 & (r_size32 | r_a1);
      r_ack       <= w_nxt_drive && (w_nxt_hold == 4'd0);
      r_berr      <= w_expire;
      r_busy      <= (w_nxt_state != S_IDLE);
    end
  end

  assign bus.o_dev_req   = r_dev_req;
  assign bus.o_dev_a1    = r_dev_a1;
  assign bus.o_ds_o_n    = r_ds_o_n;
  assign bus.o_bdieh     = r_bdieh;
  assign bus.o_bdiel     = r_bdiel;
  assign bus.o_bbridgein = r_bbridgein;
  assign bus.o_ack       = r_ack;
  assign bus.o_berr      = r_berr;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_datapath_input_ctrl.sv
// Bench for datapath_input_ctrl: device/latch/lane model, vector table, random reads.
// Timeout checks follow DATAPATH_INPUT_TIMEOUT_EN as seen by this compile.
module tb_datapath_input_ctrl;

  localparam int HOLD = 2;
  localparam int TMO  = 4;

  typedef struct {
    logic        s32;
    logic        a1;
    logic        p16;
    int          dly;
    logic [15:0] m0;
    logic [15:0] m1;
    int          lat;   // ACK cycle counting the REQ cycle as 0, for a one-cycle hold
    logic [31:0] od;
    int          ds;
    int          nf;
    logic        a1f;
    logic [2:0]  en;    // {bDIEH, bDIEL, bBRIDGEIN}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_input_ctrl_if bus ();

  datapath_input_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic        cur_p16;
  logic [15:0] cur_m0, cur_m1;
  int          cur_dly;
  int          wait_cnt = 0;
  logic [15:0] latch;
  logic [31:0] cpu_od;
  logic [31:0] dev_data;
  int          ds_cycles, en_cycles;
  logic        prev_req = 1'b0;
  logic        a1_log[$];
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, model device data, latch and CPU lanes
  task automatic step();
    @(posedge clk);
    #1;
    if (!bus.o_dev_req)   dev_data = 32'h0;
    else if (cur_p16)     dev_data = {(bus.o_dev_a1 ? cur_m1 : cur_m0), 16'h0};
    else                  dev_data = {cur_m0, cur_m1};
    if (!bus.o_ds_o_n) begin
      latch = dev_data[31:16];
      ds_cycles++;
    end
    cpu_od = {(bus.o_bdieh ? dev_data[31:16] : 16'h0),
              (bus.o_bdiel ? dev_data[15:0] : (bus.o_bbridgein ? latch : 16'h0))};
    chk("diel_and_bridge", {31'b0, bus.o_bdiel & bus.o_bbridgein}, 0);
    chk("ds_without_req", {31'b0, ~bus.o_ds_o_n & ~bus.o_dev_req}, 0);
    if (bus.o_bdieh | bus.o_bdiel | bus.o_bbridgein) en_cycles++;
    if (bus.o_dev_req && !prev_req) a1_log.push_back(bus.o_dev_a1);
    prev_req = bus.o_dev_req;
    if (bus.o_dev_req) begin
      bus.i_dev_ack = (wait_cnt >= cur_dly);
      wait_cnt++;
    end else begin
      bus.i_dev_ack = 1'b0;
      wait_cnt = 0;
    end
  endtask

  function automatic void ref_model(inout vec_t v);
    logic ea1;
    int   br, gaps;
    ea1 = v.s32 ? 1'b0 : v.a1;
    if (v.p16 && v.s32) begin
      v.nf = 2; br = 1; gaps = 1; v.a1f = 1'b1;
      v.od = {v.m0, v.m1}; v.en = 3'b101;
    end else if (v.p16) begin
      v.nf = 1; br = ea1 ? 1 : 0; gaps = 0; v.a1f = ea1;
      v.od = ea1 ? {16'h0, v.m1} : {v.m0, 16'h0};
      v.en = ea1 ? 3'b001 : 3'b100;
    end else begin
      v.nf = 1; br = 0; gaps = 0; v.a1f = ea1;
      v.od = {v.m0, v.m1}; v.en = 3'b110;
    end
    v.ds  = br;
    v.lat = v.nf * (v.dly + 1) + br + gaps + 1;
  endfunction

  task automatic setup(input vec_t v);
    cur_p16 = v.p16; cur_m0 = v.m0; cur_m1 = v.m1; cur_dly = v.dly;
    latch = ~v.m1;
    ds_cycles = 0; en_cycles = 0;
    a1_log.delete();
    bus.i_size32 = v.s32; bus.i_a1 = v.a1; bus.i_port16 = v.p16;
  endtask

  task automatic do_txn(input vec_t v);
    int          n;
    logic [31:0] od;
    logic [2:0]  en;
    logic        bsy;
    setup(v);
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
    n = 1;
    while (!bus.o_ack && n < 200) begin
      step();
      n++;
    end
    od  = cpu_od;
    en  = {bus.o_bdieh, bus.o_bdiel, bus.o_bbridgein};
    bsy = bus.o_busy;
    chk("ack_latency", n, v.lat + HOLD - 1);
    chk("cpu_od", od, v.od);
    chk("drive_enables", {29'b0, en}, {29'b0, v.en});
    chk("busy_at_ack", {31'b0, bsy}, 1);
    step();
    chk("ack_single_pulse_idle", {30'b0, bus.o_ack, bus.o_busy}, 0);
    chk("ds_low_cycles", ds_cycles, v.ds);
    chk("enable_cycles", en_cycles, HOLD);
    chk("fetch_count", a1_log.size(), v.nf);
    if (a1_log.size() > 0) chk("dev_a1_first", {31'b0, a1_log[0]}, {31'b0, v.a1f});
    if (a1_log.size() > 1) chk("dev_a1_second", {31'b0, a1_log[1]}, 0);
  endtask

  function automatic logic [8:0] outs();
    return {bus.o_dev_req, bus.o_dev_a1, bus.o_ds_o_n, bus.o_bdieh, bus.o_bdiel,
            bus.o_bbridgein, bus.o_ack, bus.o_berr, bus.o_busy};
  endfunction

  initial begin
    vec_t v;
    int   n, cnt;
    logic seen;

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_size32 = 1'b0; bus.i_a1 = 1'b0;
    bus.i_port16 = 1'b0; bus.i_dev_ack = 1'b0;
    cur_p16 = 1'b0; cur_m0 = 16'h0; cur_m1 = 16'h0; cur_dly = 0;
    repeat (3) step();
    chk("reset_outputs", {23'b0, outs()}, 32'h040);
    rst = 1'b0;
    step();

    //        s32   a1    p16  dly m0        m1        lat od            ds nf a1f   en
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 16'hCAFE, 16'hF00D, 2, 32'hCAFEF00D, 0, 1, 1'b0, 3'b110};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 0, 16'h1111, 16'hBEEF, 3, 32'h0000BEEF, 1, 1, 1'b1, 3'b001};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 3, 16'h1234, 16'h5678, 11, 32'h12345678, 1, 2, 1'b1, 3'b101};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1, 16'hA5A5, 16'h5A5A, 3, 32'hA5A50000, 0, 1, 1'b0, 3'b100};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2, 16'h0BAD, 16'hF00D, 4, 32'h0BADF00D, 0, 1, 1'b1, 3'b110};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 0, 16'h0102, 16'h0304, 5, 32'h01020304, 1, 2, 1'b1, 3'b101};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 0, 16'hDEAD, 16'hBEEF, 2, 32'hDEADBEEF, 0, 1, 1'b0, 3'b110};
    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.s32 = 1'($urandom_range(0, 1));
      v.a1  = 1'($urandom_range(0, 1));
      v.p16 = 1'($urandom_range(0, 1));
      v.dly = $urandom_range(0, 3);
      v.m0  = 16'($urandom);
      v.m1  = 16'($urandom);
      ref_model(v);
      do_txn(v);
    end

    // Reset held two cycles in the middle of DRIVE
    v = tbl[2];
    v.dly = 0;
    setup(v);
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
    n = 1;
    while (!(bus.o_bdieh | bus.o_bbridgein) && n < 50) begin
      step();
      n++;
    end
    chk("reached_drive", {31'b0, bus.o_bdieh & bus.o_bbridgein}, 1);
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      step();
      seen = seen | bus.o_ack;
    end
    chk("reset_mid_drive", {23'b0, outs()}, 32'h040);
    chk("reset_no_ack", {31'b0, seen}, 0);
    rst = 1'b0;
    step();
    chk("after_reset_idle", {23'b0, outs()}, 32'h040);

    // Back-to-back with REQ held: one fetch per transaction, one IDLE cycle between
    setup(tbl[0]);
    bus.i_req = 1'b1;
    step();
    n = 1;
    while (!bus.o_ack && n < 50) begin
      step();
      n++;
    end
    chk("b2b_first_latency", n, tbl[0].lat + HOLD - 1);
    chk("b2b_req_ignored_busy", a1_log.size(), 1);
    step();
    chk("b2b_idle_gap", {30'b0, bus.o_busy, bus.o_ack}, 0);
    step();
    chk("b2b_second_start", {30'b0, bus.o_busy, bus.o_dev_req}, 32'h3);
    bus.i_req = 1'b0;
    n = 0;
    while (!bus.o_ack && n < 50) begin
      step();
      n++;
    end
    chk("b2b_second_ack", {31'b0, bus.o_ack}, 1);
    step();
    step();
    chk("b2b_no_third", {31'b0, bus.o_busy}, 0);
    chk("b2b_fetches", a1_log.size(), 2);

    // Device never answers
    v = tbl[0];
    v.dly = 1000;
    setup(v);
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
`ifdef DATAPATH_INPUT_TIMEOUT_EN
    n = 1;
    while (!bus.o_berr && n < 50) begin
      step();
      n++;
    end
    chk("berr_cycle", n, TMO + 1);
    chk("berr_quiet_outputs", {23'b0, outs()}, 32'h042);
    step();
    chk("berr_single_pulse", {31'b0, bus.o_berr}, 0);
    chk("berr_no_enables", en_cycles, 0);
`else
    cnt = 0;
    seen = 1'b0;
    repeat (60) begin
      step();
      if (bus.o_busy) cnt++;
      seen = seen | bus.o_berr | bus.o_ack;
    end
    chk("no_timeout_busy_held", cnt, 60);
    chk("no_timeout_no_berr_ack", {31'b0, seen}, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("recover_after_reset", {23'b0, outs()}, 32'h040);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
